// File: rtl/arbitro_turnos_gato.sv
// Turn arbiter for tic-tac-toe: converts both players' button levels to one-hot
// pulses, forwards only the active player's, and sequences turns, timeouts and moves.
module arbitro_turnos_gato #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 10
) (
  input  logic       clk,
  input  logic       reset_all,
  input  logic       reset_game,
  input  logic       start,
  input  logic [4:0] p1_botones,
  input  logic [4:0] p2_botones,
  input  logic       move_ok,
  input  logic       game_end,
  output logic [4:0] boton_out,
  output logic       turno_p1,
  output logic       turno_p2,
  output logic       timeout_flag,
  output logic [3:0] moves,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    P1   = 2'd1,
    P2   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_r;
  logic [4:0]       prev1_r;
  logic [4:0]       prev2_r;
  logic [CNT_W-1:0] timer_r;
  logic [4:0]       rise_s;
  logic [4:0]       pick_s;

  // Keep only the highest-priority rising bit: elige > arriba > abajo > izq > der.
  function automatic logic [4:0] pick_one(input logic [4:0] r);
    logic [4:0] o;
    o = 5'b00000;
    if (r[4]) begin
      o = 5'b10000;
    end else if (r[3]) begin
      o = 5'b01000;
    end else if (r[2]) begin
      o = 5'b00100;
    end else if (r[1]) begin
      o = 5'b00010;
    end else if (r[0]) begin
      o = 5'b00001;
    end else begin
      o = 5'b00000;
    end
    return o;
  endfunction

  // Rising edges of the player whose turn is in effect before the clock edge.
  always_comb begin
    rise_s = 5'b00000;
    case (state_r)
      P1:      rise_s = p1_botones & ~prev1_r;
      P2:      rise_s = p2_botones & ~prev2_r;
      default: rise_s = 5'b00000;
    endcase
    pick_s = pick_one(rise_s);
  end

  // Previous-level copies track the inputs every cycle, whatever the state.
  always_ff @(posedge clk or negedge reset_all) begin
    if (!reset_all) begin
      prev1_r <= 5'b00000;
      prev2_r <= 5'b00000;
    end else begin
      prev1_r <= p1_botones;
      prev2_r <= p2_botones;
    end
  end

  // Turn sequencer with registered outputs.
  always_ff @(posedge clk or negedge reset_all) begin
    if (!reset_all) begin
      state_r      <= IDLE;
      boton_out    <= 5'b00000;
      turno_p1     <= 1'b0;
      turno_p2     <= 1'b0;
      timeout_flag <= 1'b0;
      moves        <= 4'd0;
      timer_r      <= '0;
    end else begin
      boton_out    <= 5'b00000;
      timeout_flag <= 1'b0;
      if (reset_game) begin
        state_r  <= IDLE;
        turno_p1 <= 1'b0;
        turno_p2 <= 1'b0;
        moves    <= 4'd0;
        timer_r  <= '0;
      end else begin
        case (state_r)
          IDLE: begin
            if (start) begin
              state_r  <= P1;
              turno_p1 <= 1'b1;
              turno_p2 <= 1'b0;
              timer_r  <= '0;
            end else begin
              state_r <= IDLE;
            end
          end
          P1, P2: begin
            boton_out <= pick_s;
            if (game_end) begin
              state_r  <= DONE;
              turno_p1 <= 1'b0;
              turno_p2 <= 1'b0;
            end else if (move_ok) begin
              timer_r <= '0;
              if (moves >= 4'd8) begin
                state_r  <= DONE;
                turno_p1 <= 1'b0;
                turno_p2 <= 1'b0;
                moves    <= 4'd9;
              end else begin
                state_r  <= (state_r == P1) ? P2 : P1;
                turno_p1 <= (state_r == P2);
                turno_p2 <= (state_r == P1);
                moves    <= moves + 4'd1;
              end
            end else if (pick_s != 5'b00000) begin
              // Player activity restarts the idle count.
              timer_r <= '0;
            end else if (timer_r == TIMER_LAST) begin
              state_r      <= (state_r == P1) ? P2 : P1;
              turno_p1     <= (state_r == P2);
              turno_p2     <= (state_r == P1);
              timeout_flag <= 1'b1;
              timer_r      <= '0;
            end else begin
              timer_r <= timer_r + CNT_W'(1);
            end
          end
          DONE: begin
            state_r  <= DONE;
            turno_p1 <= 1'b0;
            turno_p2 <= 1'b0;
          end
          default: begin
            state_r  <= IDLE;
            turno_p1 <= 1'b0;
            turno_p2 <= 1'b0;
          end
        endcase
      end
    end
  end

  assign state = state_r;

endmodule

// File: tb/tb_arbitro_turnos_gato.sv
// Directed bench for arbitro_turnos_gato with a short timeout (8 cycles).
module tb_arbitro_turnos_gato;

  logic       clk;
  logic       reset_all;
  logic       reset_game;
  logic       start;
  logic [4:0] p1_botones;
  logic [4:0] p2_botones;
  logic       move_ok;
  logic       game_end;
  logic [4:0] boton_out;
  logic       turno_p1;
  logic       turno_p2;
  logic       timeout_flag;
  logic [3:0] moves;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  // {state, turno_p1, turno_p2, timeout_flag, moves, boton_out}
  logic [13:0] obs;
  assign obs = {state, turno_p1, turno_p2, timeout_flag, moves, boton_out};

  arbitro_turnos_gato #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
    .clk(clk), .reset_all(reset_all), .reset_game(reset_game), .start(start),
    .p1_botones(p1_botones), .p2_botones(p2_botones), .move_ok(move_ok),
    .game_end(game_end), .boton_out(boton_out), .turno_p1(turno_p1),
    .turno_p2(turno_p2), .timeout_flag(timeout_flag), .moves(moves), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_all = 1'b1; reset_game = 1'b0; start = 1'b0; move_ok = 1'b0;
    game_end = 1'b0; p1_botones = 5'b00000; p2_botones = 5'b00000;
    #2 reset_all = 1'b0;
    #1;
    checks++;
    if (obs !== 14'b00_0_0_0_0000_00000) begin
      errors++; $display("FAIL reset_async got %b want %b", obs, 14'b00_0_0_0_0000_00000);
    end
    tick(); tick();
    reset_all = 1'b1;
    tick();
    checks++;
    if (obs !== 14'b00_0_0_0_0000_00000) begin
      errors++; $display("FAIL reset_release got %b want %b", obs, 14'b00_0_0_0_0000_00000);
    end
  endtask

  task automatic test_start_and_hold();
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (obs !== {2'd1, 1'b1, 1'b0, 1'b0, 4'd0, 5'b00000}) begin
      errors++; $display("FAIL start got %b want %b", obs, {2'd1, 1'b1, 1'b0, 1'b0, 4'd0, 5'b00000});
    end
    p1_botones = 5'b01000;
    tick();
    checks++;
    if (boton_out !== 5'b01000) begin
      errors++; $display("FAIL hold_first got %b want %b", boton_out, 5'b01000);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (boton_out !== 5'b00000) begin
        errors++; $display("FAIL hold_repeat%0d got %b want %b", i, boton_out, 5'b00000);
      end
    end
    p1_botones = 5'b00000;
  endtask

  task automatic test_gating_priority();
    p2_botones = 5'b10000;
    tick();
    checks++;
    if (obs !== {2'd1, 1'b1, 1'b0, 1'b0, 4'd0, 5'b00000}) begin
      errors++; $display("FAIL gate_p2 got %b want %b", obs, {2'd1, 1'b1, 1'b0, 1'b0, 4'd0, 5'b00000});
    end
    p2_botones = 5'b00000;
    p1_botones = 5'b11001;
    tick();
    checks++;
    if (boton_out !== 5'b10000) begin
      errors++; $display("FAIL priority got %b want %b", boton_out, 5'b10000);
    end
    p1_botones = 5'b00000;
    tick();
    checks++;
    if (boton_out !== 5'b00000) begin
      errors++; $display("FAIL priority_once got %b want %b", boton_out, 5'b00000);
    end
  endtask

  task automatic test_alternation();
    logic [1:0] exp_state;
    for (int i = 1; i <= 8; i++) begin
      move_ok = 1'b1; tick(); move_ok = 1'b0;
      exp_state = (i % 2 == 1) ? 2'd2 : 2'd1;
      checks++;
      if (obs !== {exp_state, exp_state == 2'd1, exp_state == 2'd2, 1'b0, 4'(i), 5'b00000}) begin
        errors++; $display("FAIL alt_move%0d got %b want %b", i, obs,
                           {exp_state, exp_state == 2'd1, exp_state == 2'd2, 1'b0, 4'(i), 5'b00000});
      end
    end
    move_ok = 1'b1; tick(); move_ok = 1'b0;
    checks++;
    if (obs !== {2'd3, 1'b0, 1'b0, 1'b0, 4'd9, 5'b00000}) begin
      errors++; $display("FAIL ninth_move got %b want %b", obs, {2'd3, 1'b0, 1'b0, 1'b0, 4'd9, 5'b00000});
    end
    move_ok = 1'b1; start = 1'b1; tick(); move_ok = 1'b0; start = 1'b0;
    checks++;
    if (obs !== {2'd3, 1'b0, 1'b0, 1'b0, 4'd9, 5'b00000}) begin
      errors++; $display("FAIL done_hold got %b want %b", obs, {2'd3, 1'b0, 1'b0, 1'b0, 4'd9, 5'b00000});
    end
    reset_game = 1'b1; tick(); reset_game = 1'b0;
    checks++;
    if (obs !== 14'b00_0_0_0_0000_00000) begin
      errors++; $display("FAIL reset_game got %b want %b", obs, 14'b00_0_0_0_0000_00000);
    end
  endtask

  task automatic test_timeout();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (obs !== {2'd1, 1'b1, 1'b0, 1'b0, 4'd0, 5'b00000}) begin
      errors++; $display("FAIL to_before got %b want %b", obs, {2'd1, 1'b1, 1'b0, 1'b0, 4'd0, 5'b00000});
    end
    tick();
    checks++;
    if (obs !== {2'd2, 1'b0, 1'b1, 1'b1, 4'd0, 5'b00000}) begin
      errors++; $display("FAIL to_fire got %b want %b", obs, {2'd2, 1'b0, 1'b1, 1'b1, 4'd0, 5'b00000});
    end
    tick();
    checks++;
    if (timeout_flag !== 1'b0) begin
      errors++; $display("FAIL to_single got %b want %b", timeout_flag, 1'b0);
    end
    for (int i = 0; i < 3; i++) tick();
    p2_botones = 5'b00100;
    tick();
    p2_botones = 5'b00000;
    checks++;
    if (boton_out !== 5'b00100) begin
      errors++; $display("FAIL to_p2_pulse got %b want %b", boton_out, 5'b00100);
    end
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (obs !== {2'd2, 1'b0, 1'b1, 1'b0, 4'd0, 5'b00000}) begin
      errors++; $display("FAIL to_restart got %b want %b", obs, {2'd2, 1'b0, 1'b1, 1'b0, 4'd0, 5'b00000});
    end
    tick();
    checks++;
    if (obs !== {2'd1, 1'b1, 1'b0, 1'b1, 4'd0, 5'b00000}) begin
      errors++; $display("FAIL to_fire2 got %b want %b", obs, {2'd1, 1'b1, 1'b0, 1'b1, 4'd0, 5'b00000});
    end
  endtask

  task automatic test_game_end();
    move_ok = 1'b1; tick(); move_ok = 1'b0;
    checks++;
    if (obs !== {2'd2, 1'b0, 1'b1, 1'b0, 4'd1, 5'b00000}) begin
      errors++; $display("FAIL ge_setup got %b want %b", obs, {2'd2, 1'b0, 1'b1, 1'b0, 4'd1, 5'b00000});
    end
    move_ok = 1'b1; game_end = 1'b1; tick(); move_ok = 1'b0; game_end = 1'b0;
    checks++;
    if (obs !== {2'd3, 1'b0, 1'b0, 1'b0, 4'd1, 5'b00000}) begin
      errors++; $display("FAIL ge_prec got %b want %b", obs, {2'd3, 1'b0, 1'b0, 1'b0, 4'd1, 5'b00000});
    end
    reset_game = 1'b1; tick(); reset_game = 1'b0;
    checks++;
    if (obs !== 14'b00_0_0_0_0000_00000) begin
      errors++; $display("FAIL ge_reset got %b want %b", obs, 14'b00_0_0_0_0000_00000);
    end
  endtask

  task automatic test_async_reset();
    start = 1'b1; tick(); start = 1'b0;
    move_ok = 1'b1; tick(); move_ok = 1'b0;
    p2_botones = 5'b00001;
    tick();
    checks++;
    if (obs !== {2'd2, 1'b0, 1'b1, 1'b0, 4'd1, 5'b00001}) begin
      errors++; $display("FAIL ar_pulse got %b want %b", obs, {2'd2, 1'b0, 1'b1, 1'b0, 4'd1, 5'b00001});
    end
    #2 reset_all = 1'b0;
    #1;
    checks++;
    if (obs !== 14'b00_0_0_0_0000_00000) begin
      errors++; $display("FAIL ar_immediate got %b want %b", obs, 14'b00_0_0_0_0000_00000);
    end
    tick();
    reset_all = 1'b1;
    move_ok = 1'b1; tick(); move_ok = 1'b0;
    checks++;
    if (obs !== 14'b00_0_0_0_0000_00000) begin
      errors++; $display("FAIL ar_idle got %b want %b", obs, 14'b00_0_0_0_0000_00000);
    end
    start = 1'b1; tick(); start = 1'b0;
    move_ok = 1'b1; tick(); move_ok = 1'b0;
    tick();
    checks++;
    if (obs !== {2'd2, 1'b0, 1'b1, 1'b0, 4'd1, 5'b00000}) begin
      errors++; $display("FAIL ar_held got %b want %b", obs, {2'd2, 1'b0, 1'b1, 1'b0, 4'd1, 5'b00000});
    end
    p2_botones = 5'b00000; tick();
    p2_botones = 5'b00001; tick();
    checks++;
    if (boton_out !== 5'b00001) begin
      errors++; $display("FAIL ar_fresh got %b want %b", boton_out, 5'b00001);
    end
    p2_botones = 5'b00000;
  endtask

  initial begin
    test_reset();
    test_start_and_hold();
    test_gating_priority();
    test_alternation();
    test_timeout();
    test_game_end();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
